mem_master: RTL

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master_pkg.sv | 17 +
 rtl/mem_master.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_master_pkg.sv
// Shared types and default sizing for the single-port memory master.
// Default constants match the parameter defaults of mem_master.
package mem_master_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DEPTH  = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_CAPT  = 3'd3,
    S_RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/mem_master.sv
// Request/response front end that issues one word access at a time to a memory.
// Optional out-of-range rejection is compiled in with MEM_MASTER_ADDR_CHECK_EN.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready is high only while idle; rsp_valid holds until rsp_ready.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            dbg_state
);

`ifdef MEM_MASTER_ADDR_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              addr_err;

  assign addr_err = CHECK_EN && (req_addr >= ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          // Rejected requests skip the memory entirely and answer at once.
          if (addr_err) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_we) begin
            state_d = S_WR_ISSUE;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_WR_ISSUE: state_d = S_RESP;
      S_RD_ISSUE: state_d = S_RD_CAPT;
      S_RD_CAPT: begin
        rdata_d = mem_rdata;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is either a register or a pure decode of the state.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign mem_write = (state_q == S_WR_ISSUE);
  assign mem_read  = (state_q == S_RD_ISSUE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule
